grp_pingpong_ctrl: RTL and testbench
====================================

// Module: grp_pingpong_ctrl
// PURPOSE
//  Ping-pong arbiter for the two grpBuffer banks between the group writer (frameFiller, orbAddr/orbWrEn side)
//  and the frame reader (M8, oRdEn/oAddr side). Owns bank ownership, gates per-bank we/re, muxes read data,
//  swaps banks only on reader frame boundaries when the writer has completed a group; flags under/overrun.
//  Replaces the open-loop FF_SWCH case block; sits in the clk80 domain (reader strobes pre-synchronised).
// PARAMETERS
//  DATA_W   12  word width of bank data
//  ADDR_W   10  bank address width (group = 2**ADDR_W words)
//  CNT_W    8   width of saturating error counters
// PORTS
//  clk          in   1       system clock (clk80)
//  reset        in   1       asynchronous, active-low reset (0 = reset)
//  wr_en        in   1       writer word strobe
//  wr_done      in   1       writer pulse: current group complete
//  rd_en        in   1       reader read strobe
//  rd_frm_start in   1       reader pulse: starting a new group, requests swap
//  m0_q, m1_q   in   DATA_W  bank read data
//  m0_we, m1_we out  1       gated bank write enables
//  m0_re, m1_re out  1       gated bank read enables
//  rd_q         out  DATA_W  read data to reader
//  rd_bank      out  1       bank currently owned by reader
//  underrun     out  1       1-cycle pulse: swap requested, writer bank not full
//  overrun      out  1       1-cycle pulse: write/done attempted into full bank
//  under_cnt    out  CNT_W   saturating underrun count
//  over_cnt     out  CNT_W   saturating overrun count
// BEHAVIOUR
//  - Regs: state{PRIME,RUN}, w_bank, full (writer bank complete), under/over pulses, counters.
//  - Reset (async, reset=0): state=PRIME, w_bank=0, rd_bank=1, full=0, all pulses 0, counters 0.
//    Outputs: we/re 0, rd_q 0. Reset mid-group discards all bank contents (full=0).
//  - Invariant: rd_bank == ~w_bank always.
//  - Gating (comb. from registered state): m[w_bank]_we = wr_en & ~full; m[rd_bank]_re = rd_en;
//    other bank's we/re = 0. rd_q = m[rd_bank]_q in RUN, 0 in PRIME (reader sees zeroes until first group).
//  - wr_done: full<=1. If full already 1 -> overrun pulse, over_cnt+1.
//  - wr_en while full=1: write suppressed, overrun pulse, over_cnt+1 (max one increment per cycle).
//  - rd_frm_start with full=1 (or wr_done same cycle): swap next edge: w_bank<=~w_bank, full<=0,
//    state<=RUN. Writes in the swap cycle go to the pre-swap bank (ignored if full).
//  - rd_frm_start with full=0 & no wr_done: no swap, underrun pulse, under_cnt+1; reader repeats its
//    bank (PRIME: keeps reading zeroes). Partial group in writer bank is kept and continued.
//  - Swap latency: 1 clk; new rd_bank visible on cycle after rd_frm_start; bank q has grpBuffer's own
//    1-cycle read latency, which rd_q mux does not add to (mux select registered).
//  - Counters saturate at 2**CNT_W-1, never wrap.
//  - wr_done + rd_frm_start + full=1 same cycle: swap, plus overrun (new group lost into old full flag).
// STRUCTURE
//  - Shared package dtfm_pkg: state enum {PRIME,RUN}, bank constants BANK0/BANK1, GRP_ADDR_W=10, DATA_W=12.
//  - One sub-module: sat_counter (CNT_W, inc, async active-low clear), instanced twice.
//  - FSM + bank regs in one always block; gating/mux in one comb block.
// TESTING
//  1 reset low mid-traffic -> all outputs 0, rd_bank=1, counters 0 within same cycle (async).
//  2 PRIME: 1024 wr_en, wr_done, rd_frm_start -> swap, rd_bank=0, rd_q=m0_q, m1_we follows wr_en.
//  3 rd_frm_start with no wr_done -> underrun 1 cycle, under_cnt=1, rd_bank unchanged, rd_q=0 in PRIME.
//  4 two wr_done without swap -> overrun pulse, over_cnt=1; later wr_en gated (m*_we=0), over_cnt increments.
//  5 wr_done and rd_frm_start same cycle, full=0 -> swap, no under/overrun pulse.
//  6 300 underruns with CNT_W=8 -> under_cnt holds 255; random wr/rd mix -> m0_we&m0_re never both 1.

Source files
------------

// File: rtl/dtfm_pkg.sv
// Shared types and constants for the grpBuffer ping-pong datapath.
package dtfm_pkg;

  localparam int unsigned GRP_ADDR_W = 10;
  localparam int unsigned DATA_W     = 12;

  typedef enum logic {
    PRIME = 1'b0,
    RUN   = 1'b1
  } state_e;

  localparam logic BANK0 = 1'b0;
  localparam logic BANK1 = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/grp_pingpong_ctrl.sv
// Ping-pong owner of the two grpBuffer banks: writer fills one bank while the reader drains the other,
// swapping only on reader frame starts once the writer has a complete group.
module grp_pingpong_ctrl #(
  parameter int unsigned DATA_W = dtfm_pkg::DATA_W,
  parameter int unsigned ADDR_W = dtfm_pkg::GRP_ADDR_W,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic              wr_done,
  input  logic              rd_en,
  input  logic              rd_frm_start,
  input  logic [DATA_W-1:0] m0_q,
  input  logic [DATA_W-1:0] m1_q,
  output logic              m0_we,
  output logic              m1_we,
  output logic              m0_re,
  output logic              m1_re,
  output logic [DATA_W-1:0] rd_q,
  output logic              rd_bank,
  output logic              underrun,
  output logic              overrun,
  output logic [CNT_W-1:0]  under_cnt,
  output logic [CNT_W-1:0]  over_cnt
);

  import dtfm_pkg::state_e;
  import dtfm_pkg::PRIME;
  import dtfm_pkg::RUN;
  import dtfm_pkg::BANK0;
  import dtfm_pkg::BANK1;

  if (ADDR_W == 0) begin : g_addr_w_chk
    $error("grp_pingpong_ctrl: ADDR_W must be nonzero");
  end

  state_e r_state;
  logic   r_w_bank;
  logic   r_full;
  logic   r_under;
  logic   r_over;

  state_e w_state_nxt;
  logic   w_w_bank_nxt;
  logic   w_full_nxt;
  logic   w_swap;
  logic   w_under;
  logic   w_over;
  logic   w_rd_bank;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= PRIME;
      r_w_bank <= BANK0;
      r_full   <= 1'b0;
      r_under  <= 1'b0;
      r_over   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_w_bank <= w_w_bank_nxt;
      r_full   <= w_full_nxt;
      r_under  <= w_under;
      r_over   <= w_over;
    end
  end

  // A same-cycle wr_done counts as a full writer bank for the swap decision.
  always_comb begin
    w_state_nxt  = r_state;
    w_w_bank_nxt = r_w_bank;
    w_full_nxt   = r_full;
    w_swap       = rd_frm_start & (r_full | wr_done);
    w_under      = rd_frm_start & ~r_full & ~wr_done;
    w_over       = r_full & (wr_done | wr_en);
    if (w_swap) begin
      w_state_nxt  = RUN;
      w_w_bank_nxt = ~r_w_bank;
      w_full_nxt   = 1'b0;
    end else if (wr_done) begin
      w_full_nxt = 1'b1;
    end
  end

  assign w_rd_bank = ~r_w_bank;

  // Strobe gating and read mux; everything held quiet while reset is asserted.
  always_comb begin
    m0_we = 1'b0;
    m1_we = 1'b0;
    m0_re = 1'b0;
    m1_re = 1'b0;
    rd_q  = '0;
    if (reset) begin
      if (r_w_bank == BANK0) m0_we = wr_en & ~r_full;
      else                   m1_we = wr_en & ~r_full;
      if (w_rd_bank == BANK0) m0_re = rd_en;
      else                    m1_re = rd_en;
      if (r_state == RUN) rd_q = (w_rd_bank == BANK1) ? m1_q : m0_q;
    end
  end

  assign rd_bank  = w_rd_bank;
  assign underrun = r_under;
  assign overrun  = r_over;

  sat_counter #(.CNT_W(CNT_W)) u_under_cnt (
    .clk   (clk),
    .rst_n (reset),
    .i_inc (w_under),
    .o_cnt (under_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_over_cnt (
    .clk   (clk),
    .rst_n (reset),
    .i_inc (w_over),
    .o_cnt (over_cnt)
  );

endmodule

// File: tb/tb_grp_pingpong_ctrl.sv
// Directed + random bench for grp_pingpong_ctrl with a predicted-output scoreboard.
module tb_grp_pingpong_ctrl;

  localparam int unsigned DW = 12;
  localparam int unsigned CW = 8;
  localparam int unsigned CMAX = 255;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en, wr_done, rd_en, rd_frm_start;
  logic [DW-1:0] m0_q, m1_q;
  logic          m0_we, m1_we, m0_re, m1_re;
  logic [DW-1:0] rd_q;
  logic          rd_bank, underrun, overrun;
  logic [CW-1:0] under_cnt, over_cnt;

  grp_pingpong_ctrl #(.DATA_W(DW), .ADDR_W(10), .CNT_W(CW)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_done      (wr_done),
    .rd_en        (rd_en),
    .rd_frm_start (rd_frm_start),
    .m0_q         (m0_q),
    .m1_q         (m1_q),
    .m0_we        (m0_we),
    .m1_we        (m1_we),
    .m0_re        (m0_re),
    .m1_re        (m1_re),
    .rd_q         (rd_q),
    .rd_bank      (rd_bank),
    .underrun     (underrun),
    .overrun      (overrun),
    .under_cnt    (under_cnt),
    .over_cnt     (over_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rd_bank, underrun, overrun, m0_we, m1_we, m0_re, m1_re;
    logic [CW-1:0] ucnt, ocnt;
    logic [DW-1:0] rd_q;
  } snap_t;

  snap_t sb_q[$];
  int    n_pass  = 0;
  int    n_total = 0;

  // Reference model state
  bit md_rst, md_run, md_wbank, md_full, md_under, md_over;
  int md_ucnt, md_ocnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_clear();
    md_run = 0; md_wbank = 0; md_full = 0; md_under = 0; md_over = 0;
    md_ucnt = 0; md_ocnt = 0;
  endtask

  function automatic snap_t predict();
    snap_t s;
    bit    rb;
    rb = ~md_wbank;
    s.rd_bank  = md_rst ? 1'b1 : rb;
    s.underrun = md_under;
    s.overrun  = md_over;
    s.ucnt     = CW'(md_ucnt);
    s.ocnt     = CW'(md_ocnt);
    s.m0_we    = !md_rst && !md_wbank && wr_en && !md_full;
    s.m1_we    = !md_rst &&  md_wbank && wr_en && !md_full;
    s.m0_re    = !md_rst && !rb && rd_en;
    s.m1_re    = !md_rst &&  rb && rd_en;
    s.rd_q     = (!md_rst && md_run) ? (rb ? m1_q : m0_q) : '0;
    return s;
  endfunction

  task automatic compare_out();
    snap_t s;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'(1), 32'(0));
    end else begin
      s = sb_q.pop_front();
      chk("rd_bank",   32'(rd_bank),   32'(s.rd_bank));
      chk("underrun",  32'(underrun),  32'(s.underrun));
      chk("overrun",   32'(overrun),   32'(s.overrun));
      chk("under_cnt", 32'(under_cnt), 32'(s.ucnt));
      chk("over_cnt",  32'(over_cnt),  32'(s.ocnt));
      chk("m0_we",     32'(m0_we),     32'(s.m0_we));
      chk("m1_we",     32'(m1_we),     32'(s.m1_we));
      chk("m0_re",     32'(m0_re),     32'(s.m0_re));
      chk("m1_re",     32'(m1_re),     32'(s.m1_re));
      chk("rd_q",      32'(rd_q),      32'(s.rd_q));
    end
  endtask

  task automatic model_update(input bit we, input bit wd, input bit rfs);
    bit swap, und, ovr;
    swap = rfs && (md_full || wd);
    und  = rfs && !md_full && !wd;
    ovr  = md_full && (wd || we);
    md_under = und;
    md_over  = ovr;
    if (swap) begin
      md_full  = 0;
      md_wbank = ~md_wbank;
      md_run   = 1;
    end else if (wd) begin
      md_full = 1;
    end
    if (und && md_ucnt < CMAX) md_ucnt++;
    if (ovr && md_ocnt < CMAX) md_ocnt++;
  endtask

  // One clock of stimulus, entered and left just after a falling edge.
  task automatic step(input bit we, input bit wd, input bit re, input bit rfs);
    wr_en = we; wr_done = wd; rd_en = re; rd_frm_start = rfs;
    m0_q = DW'($urandom); m1_q = DW'($urandom);
    #1;
    sb_q.push_back(predict());
    compare_out();
    chk("bank0_excl", 32'(m0_we & m0_re), 32'(0));
    @(posedge clk);
    model_update(we, wd, rfs);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    wr_en = 0; wr_done = 0; rd_en = 0; rd_frm_start = 0;
    m0_q = '0; m1_q = '0;
    md_rst = 1; model_clear();
    @(negedge clk);
    #1;
    sb_q.push_back(predict());
    compare_out();
    @(negedge clk);
    reset = 1'b1; md_rst = 0;

    // Underrun while priming: reader keeps seeing zeroes
    step(0, 0, 1, 1);
    chk("t3_underrun",  32'(underrun),  32'(1));
    chk("t3_under_cnt", 32'(under_cnt), 32'(1));
    chk("t3_rd_bank",   32'(rd_bank),   32'(1));
    chk("t3_rd_q",      32'(rd_q),      32'(0));
    step(0, 0, 1, 0);
    chk("t3_pulse_end", 32'(underrun),  32'(0));

    // Fill one group, complete it, then swap
    for (int i = 0; i < 1024; i++) step(1, 0, 1, 0);
    step(0, 1, 0, 0);
    step(0, 0, 1, 1);
    wr_en = 1; rd_en = 1; m0_q = 12'h5A5; m1_q = 12'h3C3;
    #1;
    chk("t2_rd_bank", 32'(rd_bank), 32'(0));
    chk("t2_rd_q",    32'(rd_q),    32'(12'h5A5));
    chk("t2_m1_we",   32'(m1_we),   32'(1));
    chk("t2_m0_we",   32'(m0_we),   32'(0));
    chk("t2_m0_re",   32'(m0_re),   32'(1));
    step(1, 0, 1, 0);

    // Double wr_done, then writes into the full bank
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("t4_overrun",  32'(overrun),  32'(1));
    chk("t4_over_cnt", 32'(over_cnt), 32'(1));
    wr_en = 1;
    #1;
    chk("t4_m1_we_gated", 32'(m1_we), 32'(0));
    step(1, 0, 0, 0);
    chk("t4_over_cnt2", 32'(over_cnt), 32'(2));

    // Full bank + wr_done + frame start: swap and overrun together
    step(0, 1, 0, 1);
    chk("t7_overrun",  32'(overrun),  32'(1));
    chk("t7_over_cnt", 32'(over_cnt), 32'(3));
    chk("t7_rd_bank",  32'(rd_bank),  32'(1));

    // wr_done with frame start on an empty bank: clean swap
    step(0, 1, 0, 1);
    chk("t5_rd_bank",  32'(rd_bank),  32'(0));
    chk("t5_underrun", 32'(underrun), 32'(0));
    chk("t5_overrun",  32'(overrun),  32'(0));

    // Asynchronous reset in the middle of traffic
    wr_en = 1; rd_en = 1; wr_done = 0; rd_frm_start = 0;
    #2;
    reset = 1'b0; md_rst = 1; model_clear();
    #1;
    chk("t1_m0_we",   32'(m0_we),     32'(0));
    chk("t1_m1_we",   32'(m1_we),     32'(0));
    chk("t1_m0_re",   32'(m0_re),     32'(0));
    chk("t1_m1_re",   32'(m1_re),     32'(0));
    chk("t1_rd_q",    32'(rd_q),      32'(0));
    chk("t1_rd_bank", 32'(rd_bank),   32'(1));
    chk("t1_ucnt",    32'(under_cnt), 32'(0));
    chk("t1_ocnt",    32'(over_cnt),  32'(0));
    sb_q.push_back(predict());
    compare_out();
    @(negedge clk);
    reset = 1'b1; md_rst = 0;

    // Counter saturation
    for (int i = 0; i < 300; i++) step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    chk("t6_under_sat", 32'(under_cnt), 32'(255));

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom), 1'($urandom_range(0, 15) == 0), 1'($urandom),
           1'($urandom_range(0, 15) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
